// File: rtl/pend_pkg.sv
// rtl/pend_pkg.sv - shared FSM state type and index-width helper for the pending scheduler
package pend_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // A two-line scheduler still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pend_prio_enc.sv
// rtl/pend_prio_enc.sv - MSB-priority encoder, bit N-1 maps to index 0
module pend_prio_enc
    import pend_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the highest set bit is assigned last and wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(N - 1 - i);
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/pend_prio_sched.sv
// rtl/pend_prio_sched.sv - pending-request register with MSB-priority offer/ready handshake
module pend_prio_sched
    import pend_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic [N-1:0] mask,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] pend,
    output logic         ovf,
    input  logic         ovf_clr
);

    state_t         state, state_nxt;
    logic [W-1:0]   idx_r, idx_nxt;
    logic [N-1:0]   pend_r, pend_nxt;
    logic [N-1:0]   clr_vec;
    logic           ovf_r, ovf_nxt, ovf_hit;
    logic           take;
    logic [W-1:0]   enc_idx;
    logic           enc_any;

    pend_prio_enc #(
        .N (N),
        .W (W)
    ) u_enc (
        .vec (pend_r & mask),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_r;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (enc_any) begin
                    state_nxt = OFFER;
                    idx_nxt   = enc_idx;
                end
            end
            OFFER: begin
                if (ready) begin
                    take      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-hot clear of the granted line; a new request on the same edge re-sets it.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N; i++) begin
            clr_vec[i] = take && (idx_r == W'(N - 1 - i));
        end
        pend_nxt = (pend_r & ~clr_vec) | req_in;
        ovf_hit  = |(req_in & pend_r & ~clr_vec);
        ovf_nxt  = ovf_r;
        if (ovf_hit) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx_r  <= '0;
            pend_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx_r  <= idx_nxt;
            pend_r <= pend_nxt;
            ovf_r  <= ovf_nxt;
        end
    end

    assign valid = (state == OFFER);
    assign idx   = idx_r;
    assign pend  = pend_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_pend_prio_sched.sv
// tb/tb_pend_prio_sched.sv - scoreboard bench for pend_prio_sched
module tb_pend_prio_sched;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_in;
    logic [N-1:0] mask;
    logic         ready;
    logic         valid;
    logic [W-1:0] idx;
    logic [N-1:0] pend;
    logic         ovf;
    logic         ovf_clr;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    pend_prio_sched #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .mask    (mask),
        .ready   (ready),
        .valid   (valid),
        .idx     (idx),
        .pend    (pend),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: samples mid-cycle, checks offers, handshakes, hold and the post-grant gap.
    logic         prev_valid = 1'b0;
    logic         prev_hs    = 1'b0;
    logic [W-1:0] prev_idx   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) cmp("gap_after_grant", {31'b0, valid}, 32'd0);
            if (valid && prev_valid && !prev_hs) cmp("offer_hold", {29'b0, idx}, {29'b0, prev_idx});
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) cmp("unexpected_offer", {29'b0, idx}, 32'hFFFF_FFFF);
                else cmp("offer_idx", {29'b0, idx}, {29'b0, exp_q[0]});
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) cmp("unexpected_grant", {29'b0, idx}, 32'hFFFF_FFFF);
                else cmp("grant_idx", {29'b0, idx}, {29'b0, exp_q.pop_front()});
            end
            prev_hs    = valid && ready;
            prev_valid = valid;
            prev_idx   = idx;
        end
    end

    initial begin
        rst = 1'b1; req_in = '0; mask = 8'hFF; ready = 1'b0; ovf_clr = 1'b0;
        step(2);
        cmp("rst_state", {20'b0, valid, idx, pend, ovf}, 32'd0);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step(1);
            cmp("idle_quiet", {22'b0, valid, pend, ovf}, 32'd0);
        end

        // Two requests, ready high: idx 3 then idx 5 with a gap
        ready = 1'b1; req_in = 8'b0001_0100;
        exp_q.push_back(3'd3); exp_q.push_back(3'd5);
        step(1); req_in = '0;
        cmp("pend_14", {24'b0, pend}, 32'h14);
        cmp("latency_no_valid", {31'b0, valid}, 32'd0);
        step(1);
        cmp("first_offer", {28'b0, valid, idx}, {28'b0, 1'b1, 3'd3});
        step(1);
        cmp("pend_04", {24'b0, pend}, 32'h04);
        step(1);
        cmp("second_offer", {28'b0, valid, idx}, {28'b0, 1'b1, 3'd5});
        step(1);
        cmp("pend_00", {23'b0, valid, pend}, 32'h0);

        // Stall: offer held while a higher request and mask changes arrive
        ready = 1'b0; req_in = 8'h10;
        exp_q.push_back(3'd3); exp_q.push_back(3'd0);
        step(1); req_in = '0;
        step(3); req_in = 8'h80; mask = 8'h00;
        step(1); req_in = '0;
        step(2);
        cmp("stall_hold", {20'b0, valid, idx, pend}, {20'b0, 1'b1, 3'd3, 8'h90});
        mask = 8'hFF; ready = 1'b1;
        step(1);
        cmp("after_stall_pend", {23'b0, valid, pend}, {23'b0, 1'b0, 8'h80});
        step(1);
        cmp("offer_msb", {28'b0, valid, idx}, {28'b0, 1'b1, 3'd0});
        step(1);

        // Overflow: second pulse on a pending line, one grant only
        ready = 1'b0; req_in = 8'h02;
        exp_q.push_back(3'd6);
        step(1); req_in = '0;
        step(1); req_in = 8'h02;
        step(1); req_in = '0;
        cmp("ovf_set", {31'b0, ovf}, 32'd1);
        ready = 1'b1;
        step(1);
        cmp("ovf_pend_clear", {24'b0, pend}, 32'h0);
        step(3);
        cmp("ovf_single_grant", {30'b0, valid, ovf}, 32'd1);
        ovf_clr = 1'b1;
        step(1); ovf_clr = 1'b0;
        cmp("ovf_clr", {31'b0, ovf}, 32'd0);

        // Set wins over grant-clear of the same line
        ready = 1'b0; req_in = 8'h01;
        exp_q.push_back(3'd7); exp_q.push_back(3'd7);
        step(1); req_in = '0;
        step(1); ready = 1'b1; req_in = 8'h01;
        step(1); req_in = '0;
        cmp("set_wins", {22'b0, valid, pend, ovf}, {22'b0, 1'b0, 8'h01, 1'b0});
        step(1);
        cmp("reoffer_7", {28'b0, valid, idx}, {28'b0, 1'b1, 3'd7});
        step(1);
        cmp("reoffer_done", {24'b0, pend}, 32'h0);

        // Overflow has priority over a simultaneous ovf_clr
        ready = 1'b0; req_in = 8'h01;
        exp_q.push_back(3'd7);
        step(1); req_in = '0;
        step(1); req_in = 8'h01; ovf_clr = 1'b1;
        step(1); req_in = '0; ovf_clr = 1'b0;
        cmp("ovf_over_clr", {31'b0, ovf}, 32'd1);
        ready = 1'b1;
        step(1); ovf_clr = 1'b1;
        step(1); ovf_clr = 1'b0; ready = 1'b0;
        cmp("ovf_clr2", {23'b0, ovf, pend}, 32'h0);

        // Masked pending bits retained, then released; reset mid-offer
        mask = 8'h0F; req_in = 8'hF0;
        step(1); req_in = '0;
        step(3);
        cmp("masked_no_valid", {23'b0, valid, pend}, {23'b0, 1'b0, 8'hF0});
        mask = 8'hFF;
        exp_q.push_back(3'd0);
        step(1);
        cmp("unmask_offer", {28'b0, valid, idx}, {28'b0, 1'b1, 3'd0});
        exp_q.delete();
        rst = 1'b1;
        step(1);
        cmp("rst_mid_offer", {20'b0, valid, idx, pend, ovf}, 32'd0);
        rst = 1'b0;
        step(1);
        cmp("post_rst_quiet", {31'b0, valid}, 32'd0);

        step(2);
        cmp("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
